// File: rtl/mlp_pkg.sv
// Shared sizes, widths and bus slice offsets for the two-layer integer MLP.
package mlp_pkg;

   localparam int unsigned OUT_W  = 2;
   localparam int unsigned NUM_A  = 4;
   localparam int unsigned NUM_H  = 3;
   localparam int unsigned NUM_O  = 3;
   localparam int unsigned A_W    = 4;
   localparam int unsigned W_W    = 8;
   localparam int unsigned NUM_W  = 21;
   localparam int unsigned B0_W   = 11;
   localparam int unsigned B1_W   = 17;
   localparam int unsigned H_W    = 15;
   localparam int unsigned ACC1_W = 16;
   localparam int unsigned ACC2_W = 26;

   localparam int unsigned IN_BITS = NUM_A * A_W;
   localparam int unsigned W_BITS  = NUM_W * W_W;
   localparam int unsigned B_BITS  = NUM_H * B0_W + NUM_O * B1_W;

   // Low bit of W_k inside the weight bus
   function automatic int unsigned w_lo(input int unsigned k);
      return k * W_W;
   endfunction

   // Low bit of hidden bias Bh_j inside the bias bus
   function automatic int unsigned bh_lo(input int unsigned j);
      return j * B0_W;
   endfunction

   // Low bit of output bias Bo_m; output biases follow all hidden biases
   function automatic int unsigned bo_lo(input int unsigned m);
      return NUM_H * B0_W + m * B1_W;
   endfunction

endpackage

// File: rtl/mlp_if.sv
// Feature/parameter bus into the MLP and the registered class result out of it.
interface mlp_if;
   import mlp_pkg::*;

   logic [IN_BITS-1:0] inp;
   logic [W_BITS-1:0]  weights;
   logic [B_BITS-1:0]  biases;
   logic [OUT_W-1:0]   out;

   modport master (output inp, output weights, output biases, input out);
   modport slave  (input inp, input weights, input biases, output out);

endinterface

// File: rtl/mlp_neuron.sv
// Combinational dot product of unsigned inputs with signed weights plus a signed
// bias, with optional ReLU on the result.
module mlp_neuron #(
   parameter int unsigned N_IN       = 4,
   parameter int unsigned IN_WIDTH   = 4,
   parameter int unsigned WGT_WIDTH  = 8,
   parameter int unsigned BIAS_WIDTH = 11,
   parameter int unsigned ACC_WIDTH  = 16,
   parameter int unsigned Y_WIDTH    = 15,
   parameter bit          RELU       = 1'b1
) (
   input  logic [N_IN*IN_WIDTH-1:0]  x,
   input  logic [N_IN*WGT_WIDTH-1:0] w,
   input  logic [BIAS_WIDTH-1:0]     b,
   output logic [Y_WIDTH-1:0]        y_c
);

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] xe;
   logic signed [ACC_WIDTH-1:0] we;

   // Accumulator is sized so every partial sum is exact
   always_comb begin
      acc = ACC_WIDTH'($signed(b));
      xe  = '0;
      we  = '0;
      for (int i = 0; i < int'(N_IN); i++) begin
         xe  = ACC_WIDTH'($signed({1'b0, x[i*IN_WIDTH +: IN_WIDTH]}));
         we  = ACC_WIDTH'($signed(w[i*WGT_WIDTH +: WGT_WIDTH]));
         acc = acc + xe * we;
      end
   end

   always_comb begin
      y_c = Y_WIDTH'(acc);
      if (RELU && acc[ACC_WIDTH-1]) begin
         y_c = '0;
      end
   end

endmodule

// File: rtl/mlp_top.sv
// Two-stage 4-3-3 integer MLP classifier: registered ReLU hidden layer, then a
// registered argmax over the three output scores.
module mlp_top
   import mlp_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   mlp_if.slave bus
);

   logic [NUM_H*H_W-1:0]    h_c;
   logic [NUM_H*H_W-1:0]    h_q;
   logic [NUM_O*ACC2_W-1:0] s_c;
   logic [OUT_W-1:0]        cls_c;
   logic [OUT_W-1:0]        out_q;
   logic signed [ACC2_W-1:0] best_val;
   logic signed [ACC2_W-1:0] cand;

   for (genvar j = 0; j < int'(NUM_H); j++) begin : g_hid
      localparam int unsigned WLO = w_lo(NUM_A * j);
      localparam int unsigned BLO = bh_lo(j);
      mlp_neuron #(
         .N_IN(NUM_A), .IN_WIDTH(A_W), .WGT_WIDTH(W_W), .BIAS_WIDTH(B0_W),
         .ACC_WIDTH(ACC1_W), .Y_WIDTH(H_W), .RELU(1'b1)
      ) u_hid (
         .x   (bus.inp),
         .w   (bus.weights[WLO +: NUM_A*W_W]),
         .b   (bus.biases[BLO +: B0_W]),
         .y_c (h_c[j*H_W +: H_W])
      );
   end

   // Output weights start right after the NUM_A*NUM_H hidden weights
   for (genvar m = 0; m < int'(NUM_O); m++) begin : g_out
      localparam int unsigned WLO = w_lo(NUM_A*NUM_H + NUM_H*m);
      localparam int unsigned BLO = bo_lo(m);
      mlp_neuron #(
         .N_IN(NUM_H), .IN_WIDTH(H_W), .WGT_WIDTH(W_W), .BIAS_WIDTH(B1_W),
         .ACC_WIDTH(ACC2_W), .Y_WIDTH(ACC2_W), .RELU(1'b0)
      ) u_out (
         .x   (h_q),
         .w   (bus.weights[WLO +: NUM_H*W_W]),
         .b   (bus.biases[BLO +: B1_W]),
         .y_c (s_c[m*ACC2_W +: ACC2_W])
      );
   end

   // Strict greater-than keeps the lowest index on ties
   always_comb begin
      cls_c    = '0;
      best_val = $signed(s_c[0 +: ACC2_W]);
      cand     = '0;
      for (int m = 1; m < int'(NUM_O); m++) begin
         cand = $signed(s_c[m*ACC2_W +: ACC2_W]);
         if (cand > best_val) begin
            best_val = cand;
            cls_c    = OUT_W'(m);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q   <= '0;
         out_q <= '0;
      end else begin
         h_q   <= h_c;
         out_q <= cls_c;
      end
   end

   assign bus.out = out_q;

endmodule

// File: tb/tb_mlp_top.sv
// Directed-vector bench for mlp_top with hand-computed hidden values and classes.
module tb_mlp_top;
   import mlp_pkg::*;

   logic clk;
   logic rst_n;
   mlp_if bus();

   mlp_top dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   int std_w [NUM_W] = '{88, 86, -88, -86, 59, 57, -59, -59, -12, -3, -6, -12,
                         -98, 72, 12, 1, 55, -4, 33, -72, 11};
   int std_bh[NUM_H] = '{-1, 571, -164};
   int std_bo[NUM_O] = '{-38551, -33633, 33375};
   int zero_w[NUM_W] = '{default: 0};
   int zero_h[NUM_H] = '{default: 0};
   int tw    [NUM_W] = '{default: 0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_params(input int w[NUM_W], input int bh[NUM_H], input int bo[NUM_O]);
      for (int k = 0; k < int'(NUM_W); k++) bus.weights[k*W_W +: W_W] = W_W'(w[k]);
      for (int j = 0; j < int'(NUM_H); j++) bus.biases[j*B0_W +: B0_W] = B0_W'(bh[j]);
      for (int m = 0; m < int'(NUM_O); m++)
         bus.biases[NUM_H*B0_W + m*B1_W +: B1_W] = B1_W'(bo[m]);
   endtask

   function automatic logic [15:0] pack_inp(input int a0, input int a1, input int a2, input int a3);
      return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
   endfunction

   task automatic check_h(input string tag, input int e0, input int e1, input int e2);
      check_eq({tag, ".h0"}, 32'(dut.h_q[0*H_W +: H_W]), e0);
      check_eq({tag, ".h1"}, 32'(dut.h_q[1*H_W +: H_W]), e1);
      check_eq({tag, ".h2"}, 32'(dut.h_q[2*H_W +: H_W]), e2);
   endtask

   // Drive one sample, check hidden values after one edge and the class after two
   task automatic run_scn(input string tag, input logic [15:0] v,
                          input int e0, input int e1, input int e2, input int eo);
      @(negedge clk);
      bus.inp = v;
      @(negedge clk);
      check_h(tag, e0, e1, e2);
      @(negedge clk);
      check_eq({tag, ".out"}, 32'(bus.out), eo);
   endtask

   initial begin
      rst_n   = 1'b0;
      bus.inp = '0;
      bus.weights = '0;
      bus.biases  = '0;
      load_params(std_w, std_bh, std_bo);
      repeat (3) @(negedge clk);
      check_h("reset", 0, 0, 0);
      check_eq("reset.out", 32'(bus.out), 0);
      rst_n = 1'b1;

      run_scn("zeros",  pack_inp(0, 0, 0, 0),     0,  571, 0, 0);
      run_scn("a0_15",  pack_inp(15, 0, 0, 0), 1319, 1456, 0, 1);
      run_scn("all_15", pack_inp(15, 15, 15, 15), 0, 541, 0, 0);
      run_scn("a2_15",  pack_inp(0, 0, 15, 0),    0,    0, 0, 2);

      // Back-to-back samples, one per cycle
      bus.inp = pack_inp(0, 0, 0, 0);
      @(negedge clk);
      check_eq("b2b.prev", 32'(bus.out), 2);
      bus.inp = pack_inp(15, 0, 0, 0);
      @(negedge clk);
      check_eq("b2b.s0", 32'(bus.out), 0);
      bus.inp = pack_inp(0, 0, 15, 0);
      @(negedge clk);
      check_eq("b2b.s1", 32'(bus.out), 1);
      @(negedge clk);
      check_eq("b2b.s2", 32'(bus.out), 2);

      // Ties resolve to the lowest index
      load_params(zero_w, zero_h, '{5, 5, 5});
      repeat (2) @(negedge clk);
      check_eq("tie3.out", 32'(bus.out), 0);
      load_params(zero_w, zero_h, '{0, 7, 7});
      repeat (2) @(negedge clk);
      check_eq("tie2.out", 32'(bus.out), 1);

      // Reset between edges clears out without a clock
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_eq("rst_async.out", 32'(bus.out), 0);

      tw[0]  = 1;
      tw[15] = 1;
      load_params(tw, zero_h, '{5, 5, 5});
      bus.inp = pack_inp(3, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst.e1.out", 32'(bus.out), 0);
      check_eq("post_rst.e1.h0", 32'(dut.h_q[0 +: H_W]), 3);
      @(negedge clk);
      check_eq("post_rst.e2.out", 32'(bus.out), 1);
      bus.inp = pack_inp(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check_eq("post_rst.track", 32'(bus.out), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
